// File: rtl/adc_capture.sv
// Triggered ADC capture buffer.
// Waits for a rising crossing of trig_level, records DEPTH consecutive samples,
// then allows the buffer to be read out one sample per rd_en cycle.
module adc_capture #(
   parameter int unsigned DATA_W = 14,
   parameter int unsigned DEPTH  = 32
) (
   input  logic              ref_clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              arm,
   input  logic              abort,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              done
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

   typedef enum logic [2:0] {
      StIdle,
      StPrime,
      StArmed,
      StCapture,
      StFull
   } state_t;

   state_t            state_q;
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [DATA_W-1:0] s_cur_q;
   logic [DATA_W-1:0] s_prev_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              trig_hit;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;

   // Rising crossing between the two most recent registered samples.
   always_comb begin
      trig_hit = (s_prev_q < trig_level) && (s_cur_q >= trig_level);
   end

   // Buffer write decode; an abort suppresses the write so contents stay intact.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = wr_ptr_q;
      if (!abort) begin
         case (state_q)
            StArmed: begin
               if (trig_hit) begin
                  wr_en   = 1'b1;
                  wr_addr = '0;
               end
            end
            StCapture: wr_en = 1'b1;
            default:   wr_en = 1'b0;
         endcase
      end
   end

   // Sample memory, deliberately left out of reset.
   always_ff @(posedge ref_clk) begin
      if (wr_en) begin
         mem[wr_addr] <= s_cur_q;
      end
   end

   // Sample pipeline, control FSM, pointers and registered outputs.
   always_ff @(posedge ref_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         s_cur_q  <= '0;
         s_prev_q <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         s_cur_q  <= adc_data;
         s_prev_q <= s_cur_q;
         rd_valid <= 1'b0;
         if (abort) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (arm) begin
                     state_q  <= StPrime;
                     wr_ptr_q <= '0;
                     rd_ptr_q <= '0;
                  end
               end
               // One cycle so s_prev holds a sample taken after arming.
               StPrime: begin
                  state_q <= StArmed;
                  busy    <= 1'b1;
               end
               StArmed: begin
                  if (trig_hit) begin
                     state_q  <= StCapture;
                     wr_ptr_q <= AW'(1);
                  end
               end
               StCapture: begin
                  if (wr_ptr_q == LastAddr) begin
                     state_q <= StFull;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     wr_ptr_q <= wr_ptr_q + AW'(1);
                  end
               end
               StFull: begin
                  if (rd_en) begin
                     rd_data  <= mem[rd_ptr_q];
                     rd_valid <= 1'b1;
                     if (rd_ptr_q == LastAddr) begin
                        state_q <= StIdle;
                        done    <= 1'b0;
                     end else begin
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                     end
                  end
               end
               default: begin
                  state_q <= StIdle;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: directed ramp/boundary scenarios plus a
// randomized capture checked against a trigger-search model over recorded samples.
module tb_adc_capture;

   localparam int unsigned DATA_W = 14;
   localparam int unsigned DEPTH  = 32;

   logic              ref_clk    = 1'b0;
   logic              reset_n    = 1'b0;
   logic [DATA_W-1:0] adc_data   = '0;
   logic              arm        = 1'b0;
   logic              abort      = 1'b0;
   logic [DATA_W-1:0] trig_level = '0;
   logic              rd_en      = 1'b0;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              busy;
   logic              done;

   int n_chk  = 0;
   int n_pass = 0;

   // Samples driven before each clock edge, starting with the arming edge.
   logic              rec = 1'b0;
   logic [DATA_W-1:0] hist[$];

   always #5 ref_clk = ~ref_clk;

   adc_capture #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
   ) dut (
      .ref_clk   (ref_clk),
      .reset_n   (reset_n),
      .adc_data  (adc_data),
      .arm       (arm),
      .abort     (abort),
      .trig_level(trig_level),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .busy      (busy),
      .done      (done)
   );

   task automatic cyc();
      @(negedge ref_clk);
   endtask

   task automatic set_adc(input logic [DATA_W-1:0] v);
      adc_data = v;
      if (rec) hist.push_back(v);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      set_adc(DATA_W'($urandom));
      repeat (3) cyc();
      n_chk++;
      if ({rd_data, rd_valid, busy, done} !== '0)
         $display("FAIL reset_outputs: rd_data=%0h rd_valid=%b busy=%b done=%b expected all 0",
                  rd_data, rd_valid, busy, done);
      else n_pass++;
      reset_n = 1'b1;
      cyc();
      n_chk++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL reset_release_idle: busy=%b done=%b expected 0 0", busy, done);
      else n_pass++;
   endtask

   // Ramp 0,1,2,... with level 100: the capture must hold 100..131.
   task automatic test_ramp(input string tag);
      int unsigned r;
      logic        got;
      trig_level = DATA_W'(100);
      set_adc('0);
      arm = 1'b1;
      cyc();
      arm = 1'b0;
      set_adc(DATA_W'(1));
      cyc();
      n_chk++;
      if (busy !== 1'b1) $display("FAIL %s_busy_armed: busy=%b expected 1", tag, busy);
      else n_pass++;
      r   = 1;
      got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         r++;
         set_adc(DATA_W'(r));
         cyc();
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      n_chk++;
      if (!got || r != 132)
         $display("FAIL %s_done_edge: done seen=%b at edge %0d expected 1 at edge 132", tag, got, r);
      else n_pass++;
      n_chk++;
      if (busy !== 1'b0) $display("FAIL %s_busy_full: busy=%b expected 0", tag, busy);
      else n_pass++;
      rd_en = 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) begin
         cyc();
         n_chk++;
         if (rd_valid !== 1'b1 || rd_data !== DATA_W'(100 + i))
            $display("FAIL %s_read[%0d]: rd_valid=%b rd_data=%0d expected 1 %0d",
                     tag, i, rd_valid, rd_data, 100 + i);
         else n_pass++;
      end
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0)
         $display("FAIL %s_idle_after_read: done=%b busy=%b expected 0 0", tag, done, busy);
      else n_pass++;
      cyc();
      rd_en = 1'b0;
      n_chk++;
      if (rd_valid !== 1'b0 || rd_data !== DATA_W'(131))
         $display("FAIL %s_rd_in_idle: rd_valid=%b rd_data=%0d expected 0 131", tag, rd_valid, rd_data);
      else n_pass++;
   endtask

   task automatic test_no_retrigger();
      int bad;
      trig_level = DATA_W'(100);
      set_adc(DATA_W'(200));
      repeat (2) cyc();
      arm = 1'b1;
      cyc();
      arm = 1'b0;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         cyc();
         if (busy !== 1'b1 || done !== 1'b0) bad++;
      end
      n_chk++;
      if (bad != 0) $display("FAIL no_retrig_armed: bad cycles=%0d expected 0", bad);
      else n_pass++;
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      n_chk++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL no_retrig_abort: busy=%b done=%b expected 0 0", busy, done);
      else n_pass++;
   endtask

   task automatic test_abort_arm();
      abort = 1'b1;
      arm   = 1'b1;
      cyc();
      abort = 1'b0;
      arm   = 1'b0;
      n_chk++;
      if (busy !== 1'b0) $display("FAIL abort_arm_busy0: busy=%b expected 0", busy);
      else n_pass++;
      cyc();
      n_chk++;
      if (busy !== 1'b0) $display("FAIL abort_arm_busy1: busy=%b expected 0", busy);
      else n_pass++;
   endtask

   // Random samples; rd_en held during IDLE/ARMED/CAPTURE, alternate-cycle reads in FULL.
   task automatic test_gating_random();
      int          bad;
      int          m;
      int          last;
      logic        got;
      logic [DATA_W-1:0] exp;
      bad   = 0;
      rd_en = 1'b1;
      repeat (3) begin
         cyc();
         if (rd_valid !== 1'b0) bad++;
      end
      trig_level = DATA_W'($urandom_range(2000, 14000));
      hist.delete();
      rec = 1'b1;
      arm = 1'b1;
      set_adc(DATA_W'($urandom));
      cyc();
      arm = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 600; i++) begin
         set_adc(DATA_W'($urandom));
         cyc();
         if (rd_valid !== 1'b0) bad++;
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      rd_en = 1'b0;
      rec   = 1'b0;
      n_chk++;
      if (bad != 0) $display("FAIL gate_no_valid: stray rd_valid cycles=%0d expected 0", bad);
      else n_pass++;
      m = -1;
      for (int i = 1; i < hist.size(); i++) begin
         if (hist[i-1] < trig_level && hist[i] >= trig_level) begin
            m = i;
            break;
         end
      end
      last = hist.size() - 1;
      n_chk++;
      if (!got || m < 0 || last != m + int'(DEPTH))
         $display("FAIL gate_done_edge: done=%b at edge %0d expected 1 at edge %0d", got, last,
                  m + int'(DEPTH));
      else n_pass++;
      if (m < 0) m = 0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         exp   = (m + i < hist.size()) ? hist[m+i] : '0;
         rd_en = 1'b1;
         cyc();
         rd_en = 1'b0;
         n_chk++;
         if (rd_valid !== 1'b1 || rd_data !== exp)
            $display("FAIL gate_read[%0d]: rd_valid=%b rd_data=%0h expected 1 %0h",
                     i, rd_valid, rd_data, exp);
         else n_pass++;
         cyc();
         n_chk++;
         if (rd_valid !== 1'b0 || rd_data !== exp)
            $display("FAIL gate_hold[%0d]: rd_valid=%b rd_data=%0h expected 0 %0h",
                     i, rd_valid, rd_data, exp);
         else n_pass++;
      end
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0)
         $display("FAIL gate_idle: done=%b busy=%b expected 0 0", done, busy);
      else n_pass++;
   endtask

   task automatic test_boundary();
      int unsigned L;
      logic        got;
      L          = $urandom_range(2, 16000);
      trig_level = DATA_W'(L);
      // Crossing from L-1 to L must fire and capture L first.
      set_adc(DATA_W'(L - 1));
      arm = 1'b1;
      cyc();
      arm = 1'b0;
      set_adc(DATA_W'(L));
      got = 1'b0;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      n_chk++;
      if (!got) $display("FAIL bound_fire_done: done=%b expected 1", done);
      else n_pass++;
      rd_en = 1'b1;
      cyc();
      n_chk++;
      if (rd_valid !== 1'b1 || rd_data !== DATA_W'(L))
         $display("FAIL bound_fire_first: rd_valid=%b rd_data=%0d expected 1 %0d", rd_valid,
                  rd_data, L);
      else n_pass++;
      // Abort together with rd_en in FULL cancels the read.
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      rd_en = 1'b0;
      n_chk++;
      if (rd_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
         $display("FAIL bound_abort_full: rd_valid=%b done=%b busy=%b expected 0 0 0", rd_valid,
                  done, busy);
      else n_pass++;
      // L then L+1 lies wholly above the threshold: no trigger.
      set_adc(DATA_W'(L));
      arm = 1'b1;
      cyc();
      arm = 1'b0;
      set_adc(DATA_W'(L + 1));
      repeat (40) cyc();
      n_chk++;
      if (busy !== 1'b1 || done !== 1'b0)
         $display("FAIL bound_no_fire: busy=%b done=%b expected 1 0", busy, done);
      else n_pass++;
      // Raising the level while armed takes effect at once.
      trig_level = DATA_W'(L + 2);
      set_adc(DATA_W'(L + 2));
      got = 1'b0;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
      n_chk++;
      if (!got || rd_valid !== 1'b1 || rd_data !== DATA_W'(L + 2))
         $display("FAIL bound_level_change: done=%b rd_valid=%b rd_data=%0d expected 1 1 %0d",
                  got, rd_valid, rd_data, L + 2);
      else n_pass++;
      abort = 1'b1;
      cyc();
      abort = 1'b0;
   endtask

   task automatic test_async_reset();
      int bad;
      trig_level = DATA_W'(100);
      set_adc('0);
      arm = 1'b1;
      cyc();
      arm = 1'b0;
      // Trigger lands on edge 101, so ten samples are written after edge 110.
      for (int i = 1; i <= 110; i++) begin
         set_adc(DATA_W'(i));
         cyc();
      end
      n_chk++;
      if (busy !== 1'b1) $display("FAIL areset_pre_busy: busy=%b expected 1", busy);
      else n_pass++;
      #2;
      reset_n = 1'b0;
      #1;
      n_chk++;
      if ({rd_data, rd_valid, busy, done} !== '0)
         $display("FAIL areset_async: rd_data=%0h rd_valid=%b busy=%b done=%b expected all 0",
                  rd_data, rd_valid, busy, done);
      else n_pass++;
      cyc();
      reset_n = 1'b1;
      bad     = 0;
      for (int i = 0; i < 20; i++) begin
         set_adc((i % 2 == 0) ? DATA_W'(0) : DATA_W'(200));
         cyc();
         if (busy !== 1'b0 || done !== 1'b0) bad++;
      end
      n_chk++;
      if (bad != 0) $display("FAIL areset_stay_idle: bad cycles=%0d expected 0", bad);
      else n_pass++;
      test_ramp("post_reset");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_ramp("ramp");
      test_no_retrigger();
      test_abort_arm();
      test_gating_random();
      test_boundary();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 Parameter DATA_W, default 14, ADC sample width in bits.
REQ-002 Parameter DEPTH, default 32, capture buffer depth in samples (power of two, at least 4).
REQ-003 Port ref_clk, input, 1: sample clock (10 MHz); all logic on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port adc_data, input, DATA_W: unsigned ADC sample, valid every cycle.
REQ-006 Port arm, input, 1: start request, acted on in IDLE only.
REQ-007 Port abort, input, 1: return to IDLE from any state.
REQ-008 Port trig_level, input, DATA_W: unsigned rising-edge trigger threshold.
REQ-009 Port rd_en, input, 1: readout request, one sample per asserted cycle.
REQ-010 Port rd_data, output, DATA_W: readout sample.
REQ-011 Port rd_valid, output, 1: rd_data valid this cycle.
REQ-012 Port busy, output, 1: state is ARMED or CAPTURE.
REQ-013 Port done, output, 1: state is FULL (buffer holds DEPTH samples).

Function
REQ-014 adc_data SHALL be registered once into s_cur; the previous s_cur SHALL be held in s_prev; all decisions use s_cur and s_prev.
REQ-015 States SHALL be IDLE, PRIME, ARMED, CAPTURE and FULL; the state register SHALL be one-hot or binary at implementer's choice.
REQ-016 IDLE -> PRIME when arm=1 and abort=0; wr_ptr and rd_ptr SHALL clear to 0 on this transition.
REQ-017 PRIME SHALL last exactly one cycle, loading a fresh s_prev, then go to ARMED.
REQ-018 In ARMED, trigger SHALL fire when s_prev < trig_level and s_cur >= trig_level (unsigned compare).
REQ-019 On trigger, s_cur SHALL be written to buffer address 0 in the same cycle, wr_ptr -> 1, and the state SHALL go to CAPTURE.
REQ-020 In CAPTURE, s_cur SHALL be written at wr_ptr every cycle, and wr_ptr SHALL increment.
REQ-021 When the write at address DEPTH-1 occurs, the state SHALL go to FULL; no further writes SHALL occur and no wraparound SHALL take place.
REQ-022 In FULL, rd_en=1 SHALL read address rd_ptr: rd_data and rd_valid=1 SHALL appear the next cycle, and rd_ptr SHALL increment.
REQ-023 rd_en SHALL be honoured on consecutive cycles, giving one sample per cycle.
REQ-024 After the read of address DEPTH-1 is accepted, the state SHALL go to IDLE; the final rd_valid pulse SHALL still be issued on the next cycle.
REQ-025 rd_en outside FULL SHALL be ignored: rd_valid stays 0 and rd_ptr is unchanged.
REQ-026 arm outside IDLE SHALL be ignored.
REQ-027 abort=1 SHALL force IDLE on the next edge from any state, cancel any pending rd_valid, and leave buffer contents unchanged.
REQ-028 abort and arm asserted together: abort SHALL win, and the state SHALL stay or become IDLE.
REQ-029 busy and done SHALL be registered and decoded from state, with no combinational path from inputs to outputs.
REQ-030 rd_data SHALL hold its last value when rd_valid=0.
REQ-031 trig_level SHALL be sampled every cycle; a change while ARMED takes effect immediately.

Reset
REQ-032 On reset_n=0, asynchronously: state=IDLE, wr_ptr=0, rd_ptr=0, s_cur=0, s_prev=0, rd_data=0, rd_valid=0, busy=0, done=0.
REQ-033 Buffer memory SHALL NOT be reset; its contents after reset are don't-care.
REQ-034 Reset deassertion mid-capture SHALL resume in IDLE; a new arm is required to capture.

Verification
REQ-035 Ramp trigger: adc_data ramps 0,1,2..., trig_level=100, pulse arm. Response: busy=1; done=1 after 32 captures; reading 32 samples returns 100..131 in order; then IDLE.
REQ-036 No re-trigger at level: adc_data held at 200, trig_level=100, arm. Response: stays ARMED with busy=1, done never asserts; abort returns to IDLE next cycle.
REQ-037 Readout gating: rd_en pulsed in IDLE and in CAPTURE gives no rd_valid; in FULL, rd_en on alternate cycles gives rd_valid one cycle after each rd_en, with addresses sequential.
REQ-038 Simultaneous abort+arm in IDLE: state remains IDLE, busy=0.
REQ-039 Async reset during CAPTURE at wr_ptr=10: all outputs 0 with no clock edge; after release, state is IDLE and an arm starts a clean capture from address 0.
REQ-040 Boundary: trigger at s_prev=trig_level-1, s_cur=trig_level fires; s_prev=trig_level, s_cur=trig_level+1 does not fire.
